// File: rtl/rgb2bayer_frame_ctrl.sv
// rgb2bayer_frame_ctrl: frame-level sequencer in front of the rgb2bayer datapath.
// Admits only whole, SOF-aligned frames and latches geometry/pattern per frame.
//
// Ports:
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   ctrl_start, ctrl_stop   one-cycle pulses: begin streaming / stop after frame
//   cfg_hsize, cfg_vsize    requested frame geometry (columns, rows)
//   cfg_pattern             Bayer code 0 RGGB, 1 GRBG, 2 BGGR, 3 GBRG
//   cfg_pattern_cycle       advance the pattern code by one every frame
//   err_clr                 clears the sticky error flags
//   s_in_*                  upstream AXI4-Stream handshake + TUSER/TLAST
//   s_out_tvalid/tready     gated handshake toward the converter
//   pattern_V, hsize_out,
//   vsize_out               per-frame parameters driven into the datapath
//   busy, frame_done,
//   frame_count             status: not idle, end-of-frame pulse, frame count
//   err_*                   sticky geometry / framing error flags
module rgb2bayer_frame_ctrl #(
    parameter int DIM_WIDTH                 = 16,
    parameter int MAXIMUM_NUMBER_OF_COLUMNS = 1280,
    parameter int MAXIMUM_NUMBER_OF_ROWS    = 720
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ctrl_start,
    input  logic                 ctrl_stop,
    input  logic [DIM_WIDTH-1:0] cfg_hsize,
    input  logic [DIM_WIDTH-1:0] cfg_vsize,
    input  logic [1:0]           cfg_pattern,
    input  logic                 cfg_pattern_cycle,
    input  logic                 err_clr,
    input  logic                 s_in_tvalid,
    output logic                 s_in_tready,
    input  logic                 s_in_tuser,
    input  logic                 s_in_tlast,
    output logic                 s_out_tvalid,
    input  logic                 s_out_tready,
    output logic [1:0]           pattern_V,
    output logic [DIM_WIDTH-1:0] hsize_out,
    output logic [DIM_WIDTH-1:0] vsize_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic [31:0]          frame_count,
    output logic                 err_cfg,
    output logic                 err_early_eol,
    output logic                 err_late_eol,
    output logic                 err_early_sof
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    localparam logic [DIM_WIDTH-1:0] MAX_COLS =
        DIM_WIDTH'(MAXIMUM_NUMBER_OF_COLUMNS);
    localparam logic [DIM_WIDTH-1:0] MAX_ROWS =
        DIM_WIDTH'(MAXIMUM_NUMBER_OF_ROWS);
    localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

    state_t               state;
    logic [DIM_WIDTH-1:0] col;
    logic [DIM_WIDTH-1:0] row;
    logic                 stop_pending;

    logic                 accepted;
    logic                 beat_valid;
    logic [DIM_WIDTH-1:0] col_eff;
    logic [DIM_WIDTH-1:0] row_eff;
    logic [DIM_WIDTH-1:0] hsize_m1;
    logic [DIM_WIDTH-1:0] vsize_m1;
    logic                 at_last_col;
    logic                 at_last_row;
    logic                 frame_end;
    logic                 geom_ok;
    logic                 start_ok;
    logic                 set_err_cfg;
    logic                 set_early_sof;
    logic                 set_early_eol;
    logic                 set_late_eol;

    // Handshake gating: zero-cycle, purely a function of state and inputs.
    always_comb begin
        s_out_tvalid = 1'b0;
        s_in_tready  = 1'b1;
        unique case (state)
            IDLE: begin
                s_out_tvalid = 1'b0;
                s_in_tready  = 1'b1;
            end
            WAIT_SOF: begin
                // Non-SOF beats are drained upstream without reaching the converter.
                s_out_tvalid = s_in_tvalid & s_in_tuser;
                s_in_tready  = s_in_tuser ? s_out_tready : 1'b1;
            end
            ACTIVE: begin
                s_out_tvalid = s_in_tvalid;
                s_in_tready  = s_out_tready;
            end
            default: begin
                s_out_tvalid = 1'b0;
                s_in_tready  = 1'b1;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign accepted = s_in_tvalid & s_in_tready;

    // Beats that take part in the frame: every accepted beat while ACTIVE,
    // and only the SOF beat while waiting for one.
    assign beat_valid = accepted &
                        ((state == ACTIVE) |
                         ((state == WAIT_SOF) & s_in_tuser));

    // An SOF beat always restarts the frame at column 0, row 0.
    assign col_eff = s_in_tuser ? '0 : col;
    assign row_eff = s_in_tuser ? '0 : row;

    assign hsize_m1    = hsize_out - ONE;
    assign vsize_m1    = vsize_out - ONE;
    assign at_last_col = (col_eff >= hsize_m1);
    assign at_last_row = (row_eff == vsize_m1);

    // Any EOL on the last row closes the frame, early or not.
    assign frame_end = beat_valid & s_in_tlast & at_last_row;

    assign geom_ok = (cfg_hsize != '0) && (cfg_hsize <= MAX_COLS) &&
                     (cfg_vsize != '0) && (cfg_vsize <= MAX_ROWS);

    // Stop beats start when both pulses coincide.
    assign start_ok    = (state == IDLE) & ctrl_start & ~ctrl_stop;
    assign set_err_cfg = start_ok & ~geom_ok;

    assign set_early_sof = beat_valid & (state == ACTIVE) & s_in_tuser &
                           ((col != '0) | (row != '0));
    assign set_early_eol = beat_valid & s_in_tlast & ~at_last_col;
    assign set_late_eol  = beat_valid & ~s_in_tlast & at_last_col;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            stop_pending  <= 1'b0;
            pattern_V     <= 2'd0;
            hsize_out     <= '0;
            vsize_out     <= '0;
            frame_done    <= 1'b0;
            frame_count   <= 32'd0;
            err_cfg       <= 1'b0;
            err_early_eol <= 1'b0;
            err_late_eol  <= 1'b0;
            err_early_sof <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                frame_count <= frame_count + 32'd1;
            end

            // Sticky flags: a new set condition overrides a coincident clear.
            err_cfg       <= set_err_cfg   | (err_cfg       & ~err_clr);
            err_early_eol <= set_early_eol | (err_early_eol & ~err_clr);
            err_late_eol  <= set_late_eol  | (err_late_eol  & ~err_clr);
            err_early_sof <= set_early_sof | (err_early_sof & ~err_clr);

            unique case (state)
                IDLE: begin
                    stop_pending <= 1'b0;
                    if (start_ok && geom_ok) begin
                        state     <= WAIT_SOF;
                        hsize_out <= cfg_hsize;
                        vsize_out <= cfg_vsize;
                        pattern_V <= cfg_pattern;
                        col       <= '0;
                        row       <= '0;
                    end
                end

                WAIT_SOF, ACTIVE: begin
                    // A stop coinciding with an accepted SOF beat lets that
                    // frame finish, since its first beat is already downstream.
                    if (ctrl_stop) begin
                        stop_pending <= 1'b1;
                    end

                    if (beat_valid) begin
                        state <= ACTIVE;

                        if (s_in_tlast) begin
                            col <= '0;
                            row <= at_last_row ? '0 : row_eff + ONE;
                        end else if (at_last_col) begin
                            // Missing EOL: park on the last column until TLAST.
                            col <= col_eff;
                            row <= row_eff;
                        end else begin
                            col <= col_eff + ONE;
                            row <= row_eff;
                        end

                        if (frame_end) begin
                            hsize_out <= cfg_hsize;
                            vsize_out <= cfg_vsize;
                            pattern_V <= cfg_pattern_cycle ?
                                         pattern_V + 2'd1 : cfg_pattern;
                            if (stop_pending || ctrl_stop) begin
                                state        <= IDLE;
                                stop_pending <= 1'b0;
                            end else begin
                                state <= WAIT_SOF;
                            end
                        end
                    end else if ((state == WAIT_SOF) && ctrl_stop) begin
                        state        <= IDLE;
                        stop_pending <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb2bayer_frame_ctrl.sv
// tb_rgb2bayer_frame_ctrl: randomized bench for rgb2bayer_frame_ctrl.
// A cycle-level behavioural model of the frame rules predicts every output.
module tb_rgb2bayer_frame_ctrl;

    localparam int DW = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b0;
    logic          ctrl_start = 1'b0;
    logic          ctrl_stop = 1'b0;
    logic [DW-1:0] cfg_hsize = '0;
    logic [DW-1:0] cfg_vsize = '0;
    logic [1:0]    cfg_pattern = 2'd0;
    logic          cfg_pattern_cycle = 1'b0;
    logic          err_clr = 1'b0;
    logic          s_in_tvalid = 1'b0;
    logic          s_in_tready;
    logic          s_in_tuser = 1'b0;
    logic          s_in_tlast = 1'b0;
    logic          s_out_tvalid;
    logic          s_out_tready = 1'b1;
    logic [1:0]    pattern_V;
    logic [DW-1:0] hsize_out;
    logic [DW-1:0] vsize_out;
    logic          busy;
    logic          frame_done;
    logic [31:0]   frame_count;
    logic          err_cfg;
    logic          err_early_eol;
    logic          err_late_eol;
    logic          err_early_sof;

    always #5 ap_clk = ~ap_clk;

    rgb2bayer_frame_ctrl #(
        .DIM_WIDTH(DW),
        .MAXIMUM_NUMBER_OF_COLUMNS(1280),
        .MAXIMUM_NUMBER_OF_ROWS(720)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .ctrl_start(ctrl_start),
        .ctrl_stop(ctrl_stop),
        .cfg_hsize(cfg_hsize),
        .cfg_vsize(cfg_vsize),
        .cfg_pattern(cfg_pattern),
        .cfg_pattern_cycle(cfg_pattern_cycle),
        .err_clr(err_clr),
        .s_in_tvalid(s_in_tvalid),
        .s_in_tready(s_in_tready),
        .s_in_tuser(s_in_tuser),
        .s_in_tlast(s_in_tlast),
        .s_out_tvalid(s_out_tvalid),
        .s_out_tready(s_out_tready),
        .pattern_V(pattern_V),
        .hsize_out(hsize_out),
        .vsize_out(vsize_out),
        .busy(busy),
        .frame_done(frame_done),
        .frame_count(frame_count),
        .err_cfg(err_cfg),
        .err_early_eol(err_early_eol),
        .err_late_eol(err_late_eol),
        .err_early_sof(err_early_sof)
    );

    int checks = 0;
    int errors = 0;

    // Model state: ms 0 = idle, 1 = waiting for SOF, 2 = inside a frame.
    int          ms, mcol, mrow, mh, mv, mp;
    bit          msp;
    bit          m_done;
    int unsigned m_count;
    bit          m_ecfg, m_eearly, m_elate, m_esof;

    // Stimulus controls and observations.
    bit start_req, stop_req, clr_req;
    bit bp, gaps;
    bit last_acc;
    int dut_fwd, exp_fwd, gate_bad;

    task automatic model_reset();
        ms = 0; mcol = 0; mrow = 0; mh = 0; mv = 0; mp = 0;
        msp = 0; m_done = 0; m_count = 0;
        m_ecfg = 0; m_eearly = 0; m_elate = 0; m_esof = 0;
    endtask

    task automatic do_reset(input int n);
        ap_rst = 1'b1;
        s_in_tvalid = 1'b0; s_in_tuser = 1'b0; s_in_tlast = 1'b0;
        ctrl_start = 1'b0; ctrl_stop = 1'b0; err_clr = 1'b0;
        repeat (n) @(posedge ap_clk);
        #1;
        model_reset();
        start_req = 0; stop_req = 0; clr_req = 0;
        ap_rst = 1'b0;
    endtask

    // One clock cycle: drive, observe gating, advance model and DUT.
    task automatic step(input bit tv, input bit tu, input bit tl);
        bit eo, ei, acc, fe;
        int c, r;
        s_in_tvalid  = tv;
        s_in_tuser   = tu;
        s_in_tlast   = tl;
        ctrl_start   = start_req;
        ctrl_stop    = stop_req;
        err_clr      = clr_req;
        s_out_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #3;
        if (ms == 0) begin
            eo = 0; ei = 1;
        end else if (ms == 1) begin
            eo = tv && tu; ei = tu ? s_out_tready : 1'b1;
        end else begin
            eo = tv; ei = s_out_tready;
        end
        if (s_out_tvalid !== eo || s_in_tready !== ei) gate_bad++;
        if (s_out_tvalid && s_out_tready) dut_fwd++;
        if (eo && s_out_tready) exp_fwd++;
        last_acc = tv && s_in_tready;
        acc = tv && ei;
        fe = 0;
        if (clr_req) begin
            m_ecfg = 0; m_eearly = 0; m_elate = 0; m_esof = 0;
        end
        if (ms == 0) begin
            if (start_req && !stop_req) begin
                if (cfg_hsize > 0 && cfg_hsize <= 1280 &&
                    cfg_vsize > 0 && cfg_vsize <= 720) begin
                    ms = 1; mh = int'(cfg_hsize); mv = int'(cfg_vsize);
                    mp = int'(cfg_pattern); mcol = 0; mrow = 0;
                end else begin
                    m_ecfg = 1;
                end
            end
        end else begin
            if (stop_req) msp = 1;
            if (acc && (ms == 2 || tu)) begin
                if (ms == 2 && tu && (mcol != 0 || mrow != 0)) m_esof = 1;
                c = tu ? 0 : mcol;
                r = tu ? 0 : mrow;
                if (tl) begin
                    if (c < mh - 1) m_eearly = 1;
                    mcol = 0;
                    if (r == mv - 1) begin
                        fe = 1; mrow = 0;
                    end else begin
                        mrow = r + 1;
                    end
                end else if (c >= mh - 1) begin
                    m_elate = 1; mcol = c; mrow = r;
                end else begin
                    mcol = c + 1; mrow = r;
                end
                ms = 2;
                if (fe) begin
                    mh = int'(cfg_hsize); mv = int'(cfg_vsize);
                    mp = cfg_pattern_cycle ? (mp + 1) % 4 : int'(cfg_pattern);
                    if (msp) begin
                        ms = 0; msp = 0;
                    end else begin
                        ms = 1;
                    end
                end
            end else if (ms == 1 && stop_req) begin
                ms = 0; msp = 0;
            end
        end
        @(posedge ap_clk);
        #1;
        m_done = fe;
        if (fe) m_count++;
        start_req = 0; stop_req = 0; clr_req = 0;
    endtask

    // Offer one beat until accepted, with optional random idle cycles.
    task automatic beat(input bit tu, input bit tl);
        int n;
        bit tv;
        n = 0;
        do begin
            tv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(tv, tu, tl);
            n++;
        end while (!(tv && last_acc) && n < 200);
        checks++;
        if (!(tv && last_acc)) begin
            errors++;
            $display("FAIL beat_timeout: accepted=0 required=1");
        end
    endtask

    task automatic send_line(input int n, input bit sof, input bit last);
        for (int i = 0; i < n; i++) begin
            beat(sof && i == 0, last && i == n - 1);
        end
    endtask

    task automatic send_frame(input int h, input int v);
        for (int rr = 0; rr < v; rr++) begin
            send_line(h, rr == 0, 1'b1);
        end
    endtask

    task automatic set_cfg(input int h, input int v, input int p, input bit cyc);
        cfg_hsize = DW'(h);
        cfg_vsize = DW'(v);
        cfg_pattern = 2'(p);
        cfg_pattern_cycle = cyc;
    endtask

    task automatic start_stream();
        start_req = 1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (s_in_tready !== 1'b1) begin
            errors++; $display("FAIL reset_tready: got %b want 1", s_in_tready);
        end
        checks++;
        if ({s_out_tvalid, busy, frame_done, err_cfg, err_early_eol,
             err_late_eol, err_early_sof} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b %b %b %b%b%b%b want 0",
                s_out_tvalid, busy, frame_done, err_cfg, err_early_eol,
                err_late_eol, err_early_sof);
        end
        checks++;
        if (frame_count !== 32'd0 || pattern_V !== 2'd0 ||
            hsize_out !== '0 || vsize_out !== '0) begin
            errors++; $display("FAIL reset_regs: count=%0d pat=%0d h=%0d v=%0d want 0",
                frame_count, pattern_V, hsize_out, vsize_out);
        end
    endtask

    task automatic test_basic_frame();
        do_reset(1);
        bp = 0; gaps = 0; dut_fwd = 0; exp_fwd = 0; gate_bad = 0;
        set_cfg(4, 2, 0, 0);
        start_stream();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_fwd !== 0 || busy !== 1'b1) begin
            errors++; $display("FAIL junk_drop: fwd=%0d busy=%b want 0 1", dut_fwd, busy);
        end
        send_line(4, 1'b1, 1'b1);
        send_line(3, 1'b0, 1'b0);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL early_done: got %b want 0", frame_done);
        end
        beat(1'b0, 1'b1);
        checks++;
        if (frame_done !== 1'b1 || frame_count !== 32'd1) begin
            errors++; $display("FAIL basic_done: done=%b count=%0d want 1 1",
                frame_done, frame_count);
        end
        checks++;
        if (dut_fwd !== 8 || busy !== 1'b1 || hsize_out !== 16'd4) begin
            errors++; $display("FAIL basic_pass: fwd=%0d busy=%b h=%0d want 8 1 4",
                dut_fwd, busy, hsize_out);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (frame_done !== 1'b0 || frame_done !== m_done) begin
            errors++; $display("FAIL done_pulse: got %b want 0", frame_done);
        end
        checks++;
        if (gate_bad !== 0) begin
            errors++; $display("FAIL basic_gating: bad cycles=%0d want 0", gate_bad);
        end
    endtask

    task automatic test_pattern_cycle();
        do_reset(1);
        bp = 1; gaps = 1; gate_bad = 0;
        set_cfg(4, 2, 3, 1);
        start_stream();
        checks++;
        if (pattern_V !== 2'd3) begin
            errors++; $display("FAIL pat_start: got %0d want 3", pattern_V);
        end
        for (int f = 0; f < 3; f++) begin
            send_frame(4, 2);
            checks++;
            if (pattern_V !== 2'((3 + f + 1) % 4) || pattern_V !== 2'(mp)) begin
                errors++; $display("FAIL pat_seq%0d: got %0d want %0d",
                    f, pattern_V, (3 + f + 1) % 4);
            end
        end
        checks++;
        if (frame_count !== 32'd3 || frame_count !== m_count) begin
            errors++; $display("FAIL pat_count: got %0d want 3", frame_count);
        end
        checks++;
        if (gate_bad !== 0) begin
            errors++; $display("FAIL pat_gating: bad cycles=%0d want 0", gate_bad);
        end
    endtask

    task automatic test_errors();
        do_reset(1);
        bp = 1; gaps = 1;
        set_cfg(4, 2, 2, 0);
        start_stream();
        send_line(3, 1'b1, 1'b1);
        send_line(4, 1'b0, 1'b1);
        checks++;
        if (frame_count !== 32'd1 || err_early_eol !== 1'b1 || err_late_eol !== 1'b0) begin
            errors++; $display("FAIL early_eol: count=%0d early=%b late=%b want 1 1 0",
                frame_count, err_early_eol, err_late_eol);
        end
        send_line(5, 1'b1, 1'b1);
        send_line(4, 1'b0, 1'b1);
        checks++;
        if (frame_count !== 32'd2 || err_late_eol !== 1'b1) begin
            errors++; $display("FAIL late_eol: count=%0d late=%b want 2 1",
                frame_count, err_late_eol);
        end
        send_line(2, 1'b1, 1'b0);
        checks++;
        if (err_early_sof !== 1'b0) begin
            errors++; $display("FAIL sof_premature: got %b want 0", err_early_sof);
        end
        send_frame(4, 2);
        checks++;
        if (err_early_sof !== 1'b1 || frame_count !== 32'd3 || frame_count !== m_count) begin
            errors++; $display("FAIL early_sof: sof=%b count=%0d want 1 3",
                err_early_sof, frame_count);
        end
        checks++;
        if ({err_early_eol, err_late_eol, err_early_sof} !==
            {m_eearly, m_elate, m_esof}) begin
            errors++; $display("FAIL err_model: got %b%b%b want %b%b%b",
                err_early_eol, err_late_eol, err_early_sof, m_eearly, m_elate, m_esof);
        end
        clr_req = 1;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({err_cfg, err_early_eol, err_late_eol, err_early_sof} !== 4'b0) begin
            errors++; $display("FAIL err_clr: got %b%b%b%b want 0000",
                err_cfg, err_early_eol, err_late_eol, err_early_sof);
        end
    endtask

    task automatic test_stop_backpressure();
        do_reset(1);
        bp = 1; gaps = 1; dut_fwd = 0; exp_fwd = 0; gate_bad = 0;
        set_cfg(4, 2, 1, 0);
        start_stream();
        send_line(4, 1'b1, 1'b1);
        send_line(2, 1'b0, 1'b0);
        stop_req = 1;
        send_line(2, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0 || s_in_tready !== 1'b1) begin
            errors++; $display("FAIL stop_idle: busy=%b tready=%b want 0 1", busy, s_in_tready);
        end
        checks++;
        if (dut_fwd !== 8 || dut_fwd !== exp_fwd || frame_count !== 32'd1) begin
            errors++; $display("FAIL stop_beats: fwd=%0d exp=%0d count=%0d want 8 8 1",
                dut_fwd, exp_fwd, frame_count);
        end
        start_stream();
        send_frame(4, 2);
        checks++;
        if (busy !== 1'b1 || frame_count !== 32'd2) begin
            errors++; $display("FAIL stop_cleared: busy=%b count=%0d want 1 2",
                busy, frame_count);
        end
        checks++;
        if (gate_bad !== 0) begin
            errors++; $display("FAIL stop_gating: bad cycles=%0d want 0", gate_bad);
        end
    endtask

    task automatic test_cfg_errors();
        do_reset(1);
        bp = 0; gaps = 0;
        set_cfg(0, 2, 0, 0);
        start_stream();
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL cfg_h0: err=%b busy=%b want 1 0", err_cfg, busy);
        end
        clr_req = 1;
        step(1'b0, 1'b0, 1'b0);
        set_cfg(1281, 2, 0, 0);
        start_stream();
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL cfg_h1281: err=%b busy=%b want 1 0", err_cfg, busy);
        end
        set_cfg(4, 0, 0, 0);
        clr_req = 1;
        start_stream();
        checks++;
        if (err_cfg !== 1'b1) begin
            errors++; $display("FAIL cfg_set_wins: got %b want 1", err_cfg);
        end
        clr_req = 1;
        step(1'b0, 1'b0, 1'b0);
        set_cfg(4, 2, 2, 0);
        stop_req = 1;
        start_stream();
        checks++;
        if (busy !== 1'b0 || err_cfg !== 1'b0 || hsize_out !== '0) begin
            errors++; $display("FAIL start_stop: busy=%b err=%b h=%0d want 0 0 0",
                busy, err_cfg, hsize_out);
        end
        set_cfg(1280, 720, 1, 0);
        start_stream();
        checks++;
        if (busy !== 1'b1 || hsize_out !== 16'd1280 || vsize_out !== 16'd720 ||
            pattern_V !== 2'd1 || err_cfg !== m_ecfg) begin
            errors++; $display("FAIL cfg_max: busy=%b h=%0d v=%0d pat=%0d want 1 1280 720 1",
                busy, hsize_out, vsize_out, pattern_V);
        end
        stop_req = 1;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL wait_stop: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        bp = 0; gaps = 0;
        set_cfg(3, 3, 1, 0);
        start_stream();
        send_line(3, 1'b1, 1'b1);
        send_line(3, 1'b0, 1'b1);
        send_line(2, 1'b0, 1'b0);
        cfg_hsize = 16'd5;
        cfg_pattern = 2'd2;
        beat(1'b0, 1'b1);
        checks++;
        if (hsize_out !== 16'd5 || vsize_out !== 16'd3 || pattern_V !== 2'd2) begin
            errors++; $display("FAIL reload: h=%0d v=%0d pat=%0d want 5 3 2",
                hsize_out, vsize_out, pattern_V);
        end
        send_frame(5, 3);
        checks++;
        if (frame_count !== 32'd2 || frame_count !== m_count ||
            {err_early_eol, err_late_eol, err_early_sof} !== 3'b0) begin
            errors++; $display("FAIL b2b: count=%0d errs=%b%b%b want 2 000",
                frame_count, err_early_eol, err_late_eol, err_early_sof);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        bp = 0; gaps = 0;
        set_cfg(4, 2, 3, 0);
        start_stream();
        send_line(4, 1'b1, 1'b1);
        send_line(2, 1'b0, 1'b0);
        do_reset(1);
        checks++;
        if (s_in_tready !== 1'b1 || s_out_tvalid !== 1'b0 || busy !== 1'b0 ||
            frame_done !== 1'b0) begin
            errors++; $display("FAIL midrst_hs: tready=%b tvalid=%b busy=%b done=%b want 1 0 0 0",
                s_in_tready, s_out_tvalid, busy, frame_done);
        end
        checks++;
        if (frame_count !== 32'd0 || pattern_V !== 2'd0 || hsize_out !== '0 ||
            vsize_out !== '0) begin
            errors++; $display("FAIL midrst_regs: count=%0d pat=%0d h=%0d v=%0d want 0",
                frame_count, pattern_V, hsize_out, vsize_out);
        end
        start_stream();
        send_frame(4, 2);
        checks++;
        if (frame_count !== 32'd1) begin
            errors++; $display("FAIL midrst_restart: count=%0d want 1", frame_count);
        end
    endtask

    initial begin
        model_reset();
        bp = 0; gaps = 0; dut_fwd = 0; exp_fwd = 0; gate_bad = 0;
        start_req = 0; stop_req = 0; clr_req = 0; last_acc = 0;
        test_reset();
        test_basic_frame();
        test_pattern_cycle();
        test_errors();
        test_stop_backpressure();
        test_cfg_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
